seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: active-high hex glyphs,
// all-off/all-on patterns and the digit-index width helper.
package seg_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_ALL = 7'h7F;

  // Width of the digit index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaled digit slots with a dead cycle,
// frame-synchronous double buffering, leading-zero blanking and output polarity.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned EN_ACTIVE_LOW  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic                  load,
  output logic [DIGITS-1:0]     en,
  output logic [6:0]            y,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned       IDX_W    = idx_width(DIGITS);
  localparam logic [DIV_W-1:0]  CNT_MAX  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_INV   = (EN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? SEG_ALL : SEG_OFF;
  localparam logic              DP_INV   = (SEG_ACTIVE_LOW != 0);

  logic [DIV_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                dead;
  logic [4*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]   act_dp;
  logic [4*DIGITS-1:0] pend_data;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_valid;

  logic                tick;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   onehot;
  logic [DIGITS-1:0]   lz_blank;
  logic                digit_blank;

  assign tick     = enable && (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_LAST);
  assign cur_nib  = act_data[4*idx +: 4];

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (seg_raw)
  );

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  // lz_blank[i] is set when nibbles i..DIGITS-1 are all zero; digit 0 stays clear.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_blank = '0;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run && (act_data[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  assign digit_blank = blank_lz && lz_blank[idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      idx  <= '0;
      dead <= 1'b0;
    end else begin
      dead <= tick;
      if (enable) begin
        if (tick) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // A load landing on the frame boundary goes straight to the active buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_data   <= '0;
      act_dp     <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        act_data <= data_in;
        act_dp   <= dp_in;
      end else if (pend_valid) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_data  <= data_in;
      pend_dp    <= dp_in;
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en          <= EN_INV;
      y           <= SEG_INV;
      dp          <= DP_INV;
      frame_start <= 1'b0;
    end else begin
      frame_start <= dead && (idx == '0);
      if (!enable || dead) begin
        en <= EN_INV;
        y  <= SEG_INV;
        dp <= DP_INV;
      end else begin
        en <= onehot ^ EN_INV;
        if (digit_blank) begin
          y  <= SEG_INV;
          dp <= DP_INV;
        end else begin
          y  <= seg_raw ^ SEG_INV;
          dp <= act_dp[idx] ^ DP_INV;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 4-cycle slots, active-low outputs): a
// cycle model feeds a scoreboard queue, plus frame-level directed checks.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b1;
  logic [15:0] data_in  = '0;
  logic [3:0]  dp_in    = '0;
  logic        blank_lz = 1'b0;
  logic        load     = 1'b0;
  logic [3:0]  en;
  logic [6:0]  y;
  logic        dp;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .DIV_W          (3),
    .EN_ACTIVE_LOW  (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .load        (load),
    .en          (en),
    .y           (y),
    .dp          (dp),
    .frame_start (frame_start)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  typedef struct packed {
    logic [3:0] en;
    logic [6:0] y;
    logic       dp;
    logic       fs;
  } out_t;

  int unsigned m_cnt, m_idx;
  logic        m_dead, m_pv;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_actdp, m_penddp;
  logic        m_tick, m_bnd;
  out_t        sb_q [$];

  assign m_tick = enable && (m_cnt == SCAN_DIV - 1);
  assign m_bnd  = m_tick && (m_idx == DIGITS - 1);

  function automatic out_t model_out();
    out_t        o;
    logic [15:0] sh;
    o.en = 4'hF;
    o.y  = 7'h7F;
    o.dp = 1'b1;
    o.fs = m_dead && (m_idx == 0);
    if (enable && !m_dead) begin
      o.en = ~(4'b0001 << m_idx);
      sh   = m_act >> (4 * m_idx);
      if (!(blank_lz && m_idx != 0 && sh == 16'h0)) begin
        o.y  = ~hex_tab[sh[3:0]];
        o.dp = ~m_actdp[m_idx];
      end
    end
    return o;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt   <= 0;
      m_idx   <= 0;
      m_dead  <= 1'b0;
      m_pv    <= 1'b0;
      m_act   <= '0;
      m_pend  <= '0;
      m_actdp <= '0;
      m_penddp <= '0;
      sb_q.delete();
    end else begin
      sb_q.push_back(model_out());
      if (m_bnd) begin
        if (load) begin
          m_act   <= data_in;
          m_actdp <= dp_in;
        end else if (m_pv) begin
          m_act   <= m_pend;
          m_actdp <= m_penddp;
        end
        m_pv <= 1'b0;
      end else if (load) begin
        m_pend   <= data_in;
        m_penddp <= dp_in;
        m_pv     <= 1'b1;
      end
      m_dead <= m_tick;
      if (enable) begin
        m_cnt <= m_tick ? 0 : m_cnt + 1;
        m_idx <= m_tick ? (m_idx + 1) % DIGITS : m_idx;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && sb_q.size() > 0)
      check("sb", {en, y, dp, frame_start}, sb_q.pop_front());
  end

  logic tear_watch = 1'b0;
  logic saw_a      = 1'b0;
  always @(negedge clk) begin
    if (tear_watch && y == 7'h08) saw_a <= 1'b1;
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("frame_start_timeout", 32'(frame_start), 32'd1);
  endtask

  // yt holds the lit y pattern per digit, digit 0 in bits [6:0].
  task automatic check_frame(input string tag, input logic [27:0] yt);
    bit          ok;
    int unsigned slot, ph;
    logic [3:0]  e_en;
    logic [6:0]  e_y;
    wait_frame_start(ok);
    if (ok) begin
      for (int unsigned k = 0; k <= 16; k++) begin
        if (k > 0) @(negedge clk);
        slot = (k % 16) / 4;
        ph   = k % 4;
        check($sformatf("%s_fs%0d", tag, k), 32'(frame_start), 32'(k % 16 == 0));
        if (k < 16) begin
          e_en = (ph == 0) ? 4'hF : ~(4'b0001 << slot);
          e_y  = (ph == 0) ? 7'h7F : yt[7*slot +: 7];
          check($sformatf("%s_en%0d", tag, k), 32'(en), 32'(e_en));
          check($sformatf("%s_y%0d", tag, k), 32'(y), 32'(e_y));
        end
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit found;

    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_en", 32'(en), 32'hF);
    check("rst_y", 32'(y), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    found = 1'b0;
    for (int unsigned i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (en !== 4'hF) found = 1'b1;
    end
    check("first_en", 32'(en), 32'hE);

    do_load(16'h1234, 4'h0);
    check_frame("scan", {7'h79, 7'h24, 7'h30, 7'h19});

    tear_watch = 1'b1;
    repeat (4) @(negedge clk);
    do_load(16'hAAAA, 4'h0);
    do_load(16'h5555, 4'h0);
    check_frame("tear", {7'h12, 7'h12, 7'h12, 7'h12});
    check("no_A", 32'(saw_a), 32'd0);
    tear_watch = 1'b0;

    found = 1'b0;
    for (int unsigned i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (m_idx == DIGITS - 1 && m_cnt == SCAN_DIV - 1) found = 1'b1;
    end
    check("bnd_found", 32'(found), 32'd1);
    data_in = 16'h0F0F;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    check_frame("bypass", {7'h40, 7'h0E, 7'h40, 7'h0E});

    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    check_frame("lz70", {7'h7F, 7'h7F, 7'h78, 7'h40});
    do_load(16'h0000, 4'h0);
    check_frame("lz00", {7'h7F, 7'h7F, 7'h7F, 7'h40});
    blank_lz = 1'b0;

    do_load(16'h1234, 4'b0101);
    found = 1'b0;
    for (int unsigned i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (en === 4'hB) found = 1'b1;
    end
    check("hold_found", 32'(found), 32'd1);
    enable = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_en%0d", i), 32'(en), 32'hF);
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_en0", 32'(en), 32'hB);
    @(negedge clk);
    check("resume_en1", 32'(en), 32'hB);
    @(negedge clk);
    check("resume_dead", 32'(en), 32'hF);

    for (int unsigned i = 0; i < 240; i++) begin
      @(negedge clk);
      load    = ($urandom_range(0, 9) == 0);
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      enable  = ($urandom_range(0, 11) != 0);
    end
    @(negedge clk);
    load     = 1'b0;
    enable   = 1'b1;
    blank_lz = 1'b0;

    repeat (6) @(negedge clk);
    do_load(16'h9999, 4'hF);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_en", 32'(en), 32'hF);
    check("mid_rst_y", 32'(y), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'd1);
    check("mid_rst_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    check_frame("post_rst", {7'h40, 7'h40, 7'h40, 7'h40});

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
